// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the arbitrated ALU: datapath width, function-code
// width and the five recognised function codes, plus a decode helper that
// tells whether a code is one the ALU implements.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int FUNC_W = 6;

  localparam logic [FUNC_W-1:0] ALU_ADD = 6'd32;
  localparam logic [FUNC_W-1:0] ALU_SUB = 6'd34;
  localparam logic [FUNC_W-1:0] ALU_AND = 6'd36;
  localparam logic [FUNC_W-1:0] ALU_OR  = 6'd37;
  localparam logic [FUNC_W-1:0] ALU_SLT = 6'd42;

  function automatic logic is_legal_func(input logic [FUNC_W-1:0] f);
    return (f == ALU_ADD) || (f == ALU_SUB) || (f == ALU_AND) ||
           (f == ALU_OR)  || (f == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the requester-side handshake/payload bus and the response slot of
// the shared-ALU arbiter.
//   req_valid  [NUM_REQ]          per-requester request valid
//   req_ready  [NUM_REQ]          per-requester accept (one-hot or zero)
//   req_signal [6*NUM_REQ]        function codes, slice i = [6i+5:6i]
//   req_dataA  [32*NUM_REQ]       operand A, slice i = [32i+31:32i]
//   req_dataB  [32*NUM_REQ]       operand B, same slicing
//   rsp_valid/rsp_ready           response slot handshake
//   rsp_data [32], rsp_id [ID_W], rsp_err   response payload
// Modports: master = requesters + response consumer, slave = arbiter.
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]                        req_valid;
  logic [NUM_REQ-1:0]                        req_ready;
  logic [alu_pkg::FUNC_W*NUM_REQ-1:0]        req_signal;
  logic [alu_pkg::DATA_W*NUM_REQ-1:0]        req_dataA;
  logic [alu_pkg::DATA_W*NUM_REQ-1:0]        req_dataB;
  logic                                      rsp_valid;
  logic                                      rsp_ready;
  logic [alu_pkg::DATA_W-1:0]                rsp_data;
  logic [ID_W-1:0]                           rsp_id;
  logic                                      rsp_err;

  modport master (
    output req_valid, req_signal, req_dataA, req_dataB, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_signal, req_dataA, req_dataB, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational 32-bit ALU: AND/OR/ADD/SUB/SLT. Arithmetic wraps modulo
// 2^32; SLT reports the sign bit of the raw difference (no overflow
// correction). Unknown codes, and any code while reset is held, give 0.
//   i_reset          forces the output to 0
//   i_func [6]       function code
//   i_a, i_b [32]    signed operands
//   o_result [32]    result
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic                     i_reset,
  input  logic [FUNC_W-1:0]        i_func,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_result
);

  logic signed [DATA_W-1:0] w_diff;

  always_comb begin
    w_diff   = i_a - i_b;
    o_result = '0;
    if (!i_reset) begin
      case (i_func)
        ALU_AND: o_result = i_a & i_b;
        ALU_OR:  o_result = i_a | i_b;
        ALU_ADD: o_result = i_a + i_b;
        ALU_SUB: o_result = w_diff;
        ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, w_diff[DATA_W-1]};
        default: o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: finds the first set bit of i_req
// searching upward from i_ptr with wrap-around.
//   i_req  [NUM_REQ]  candidate requests (already qualified by the caller)
//   i_ptr  [IDX_W]    highest-priority index, must be < NUM_REQ
//   o_gnt  [NUM_REQ]  one-hot grant, zero when nothing is requested
//   o_idx  [IDX_W]    binary index of the grant (0 when none)
//   o_any             a grant was made
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Pointer is always below NUM_REQ, so a single subtraction wraps.
      j = int'(i_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU among NUM_REQ requesters with round-robin arbitration and a
// single registered response slot (result + requester ID), 1-cycle latency.
//   clk     rising-edge clock
//   reset   synchronous active-high reset (also resets the ALU)
//   bus     alu_arbiter_if.slave: request vectors in, req_ready out,
//           response slot out with rsp_ready in
// Build option: define ALU_ARB_OPCHECK_EN to flag unrecognised function
// codes with rsp_err=1 and rsp_data=0; otherwise rsp_err is tied 0.
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  logic                     r_rsp_vld_p1;
  logic [DATA_W-1:0]        r_rsp_data_p1;
  logic [ID_W-1:0]          r_rsp_id_p1;
  logic [ID_W-1:0]          r_ptr;

  logic                     w_slot_free;
  logic                     w_can_grant;
  logic [NUM_REQ-1:0]       w_req_q;
  logic [NUM_REQ-1:0]       w_gnt;
  logic [ID_W-1:0]          w_idx;
  logic                     w_any;
  logic [ID_W-1:0]          w_ptr_nxt;
  logic [FUNC_W-1:0]        w_func;
  logic signed [DATA_W-1:0] w_a;
  logic signed [DATA_W-1:0] w_b;
  logic signed [DATA_W-1:0] w_alu_out;
  logic [DATA_W-1:0]        w_rsp_data;

  // Grant depends only on valids, pointer and slot state, never on payload.
  assign w_slot_free = !r_rsp_vld_p1 || bus.rsp_ready;
  assign w_can_grant = w_slot_free && !reset;
  assign w_req_q     = bus.req_valid & {NUM_REQ{w_can_grant}};

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_picker (
    .i_req (w_req_q),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign bus.req_ready = w_gnt;
  assign w_ptr_nxt     = (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;

  // Idle cycles present ADD 0+0 so the ALU never sees X operands.
  always_comb begin
    w_func = ALU_ADD;
    w_a    = '0;
    w_b    = '0;
    if (w_any) begin
      w_func = bus.req_signal[int'(w_idx)*FUNC_W +: FUNC_W];
      w_a    = bus.req_dataA[int'(w_idx)*DATA_W +: DATA_W];
      w_b    = bus.req_dataB[int'(w_idx)*DATA_W +: DATA_W];
    end
  end

  alu u_alu (
    .i_reset  (reset),
    .i_func   (w_func),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_alu_out)
  );

`ifdef ALU_ARB_OPCHECK_EN
  logic w_legal;
  logic r_rsp_err_p1;

  assign w_legal    = is_legal_func(w_func);
  assign w_rsp_data = w_legal ? w_alu_out : '0;
`else
  assign w_rsp_data = w_alu_out;
`endif

  // ---- stage p0 -> p1: response slot and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_vld_p1  <= 1'b0;
      r_rsp_data_p1 <= '0;
      r_rsp_id_p1   <= '0;
      r_ptr         <= '0;
    end else if (w_any) begin
      r_rsp_vld_p1  <= 1'b1;
      r_rsp_data_p1 <= w_rsp_data;
      r_rsp_id_p1   <= w_idx;
      r_ptr         <= w_ptr_nxt;
    end else if (bus.rsp_ready) begin
      // Drain without refill: data and id keep their last values.
      r_rsp_vld_p1  <= 1'b0;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_err_p1 <= 1'b0;
    end else if (w_any) begin
      r_rsp_err_p1 <= !w_legal;
    end
  end

  assign bus.rsp_err = r_rsp_err_p1;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_valid = r_rsp_vld_p1;
  assign bus.rsp_data  = r_rsp_data_p1;
  assign bus.rsp_id    = r_rsp_id_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NR = 4;
  localparam int IW = 2;
`ifdef ALU_ARB_OPCHECK_EN
  localparam logic OPCHK = 1'b1;
`else
  localparam logic OPCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

  alu_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          r;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        e;
  } vec_t;

  vec_t tbl[11];

  // reference model state
  bit          m_act[NR];
  logic [5:0]  p_f[NR];
  logic [31:0] p_a[NR];
  logic [31:0] p_b[NR];
  bit          m_vld;
  logic [31:0] m_data;
  int          m_id;
  bit          m_err;
  int          m_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.req_valid  = '0;
    bus.req_signal = '0;
    bus.req_dataA  = '0;
    bus.req_dataB  = '0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]           = 1'b1;
    bus.req_signal[i*6 +: 6]   = f;
    bus.req_dataA[i*32 +: 32]  = a;
    bus.req_dataB[i*32 +: 32]  = b;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_rsp(input string nm, input logic v, input logic [31:0] d, input int id, input logic e);
    chk({nm, "_valid"}, {31'b0, bus.rsp_valid}, {31'b0, v});
    chk({nm, "_data"},  bus.rsp_data, d);
    chk({nm, "_id"},    {30'b0, bus.rsp_id}, id);
    chk({nm, "_err"},   {31'b0, bus.rsp_err}, {31'b0, e});
  endtask

  // ALU behaviour from the arithmetic rules, independent of the RTL.
  function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    if (f == 6'd32) return a + b;
    if (f == 6'd34) return d;
    if (f == 6'd36) return a & b;
    if (f == 6'd37) return a | b;
    if (f == 6'd42) return (d >= 32'h8000_0000) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  function automatic bit ref_illegal(input logic [5:0] f);
    return !(f == 6'd32 || f == 6'd34 || f == 6'd36 || f == 6'd37 || f == 6'd42);
  endfunction

  initial begin
    logic [31:0] fair_d[NR];
    int g;
    logic [NR-1:0] exp_rdy;

    tbl[0]  = '{0, ALU_ADD, 32'd5,         32'd7,         32'd12,        1'b0};
    tbl[1]  = '{1, ALU_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
    tbl[2]  = '{2, ALU_AND, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0};
    tbl[3]  = '{3, ALU_OR,  32'hF0F0,      32'h0F0F,      32'hFFFF,      1'b0};
    tbl[4]  = '{0, ALU_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
    tbl[5]  = '{1, ALU_SLT, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
    tbl[6]  = '{2, ALU_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    tbl[7]  = '{3, ALU_SLT, 32'h8000_0000, 32'd1,         32'd0,         1'b0};
    tbl[8]  = '{0, ALU_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};
    tbl[9]  = '{1, 6'd0,    32'd1,         32'd1,         32'd0,         OPCHK};
    tbl[10] = '{2, 6'd33,   32'd9,         32'd9,         32'd0,         OPCHK};

    // ---- reset state ----
    reset = 1'b1;
    clr();
    tick();
    tick();
    chk_rsp("reset", 1'b0, 32'd0, 0, 1'b0);
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("ready_in_reset", {28'b0, bus.req_ready}, 32'd0);
    clr();
    reset = 1'b0;
    tick();

    // ---- single request: req0 ADD 5+7 ----
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    bus.rsp_ready = 1'b1;
    #1;
    chk("single_ready", {28'b0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = '0;
    chk_rsp("single", 1'b1, 32'd12, 0, 1'b0);

    // ---- table of single-requester operations ----
    for (int t = 0; t < 11; t++) begin
      clr();
      bus.rsp_ready = 1'b1;
      set_req(tbl[t].r, tbl[t].f, tbl[t].a, tbl[t].b);
      #1;
      chk($sformatf("tbl%0d_ready", t), {28'b0, bus.req_ready}, 32'd1 << tbl[t].r);
      tick();
      bus.req_valid = '0;
      chk_rsp($sformatf("tbl%0d", t), 1'b1, tbl[t].d, tbl[t].r, tbl[t].e);
    end

    // ---- fairness: all four valid continuously ----
    clr();
    reset_pulse();
    set_req(0, ALU_AND, 32'hF0F0, 32'hFF00);
    set_req(1, ALU_OR,  32'hF0F0, 32'h0F0F);
    set_req(2, ALU_SUB, 32'd3,    32'd5);
    set_req(3, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    fair_d[0] = 32'hF000; fair_d[1] = 32'hFFFF; fair_d[2] = 32'hFFFF_FFFE; fair_d[3] = 32'd1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 2*NR; k++) begin
      #1;
      chk($sformatf("fair%0d_ready", k), {28'b0, bus.req_ready}, 32'd1 << (k % NR));
      tick();
      chk_rsp($sformatf("fair%0d", k), 1'b1, fair_d[k % NR], k % NR, 1'b0);
    end

    // ---- backpressure ----
    clr();
    reset_pulse();
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    #1;
    chk("bp_first_ready", {28'b0, bus.req_ready}, 32'd1);
    tick();
    clr();
    set_req(1, ALU_OR, 32'hA0, 32'h0B);
    set_req(2, ALU_ADD, 32'd10, 32'd20);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k), {28'b0, bus.req_ready}, 32'd0);
      tick();
      chk_rsp($sformatf("bp%0d_hold", k), 1'b1, 32'd3, 0, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {28'b0, bus.req_ready}, 32'h2);
    tick();
    bus.req_valid[1] = 1'b0;
    chk_rsp("bp_req1", 1'b1, 32'hAB, 1, 1'b0);
    #1;
    chk("bp_req2_ready", {28'b0, bus.req_ready}, 32'h4);
    tick();
    bus.req_valid[2] = 1'b0;
    chk_rsp("bp_req2", 1'b1, 32'd30, 2, 1'b0);
    tick();
    chk_rsp("drain_only", 1'b0, 32'd30, 2, 1'b0);

    // ---- wrap: after req3 grant, req0 beats req3 ----
    set_req(3, ALU_ADD, 32'd3, 32'd3);
    #1;
    chk("wrap_r3_ready", {28'b0, bus.req_ready}, 32'h8);
    tick();
    chk_rsp("wrap_r3", 1'b1, 32'd6, 3, 1'b0);
    set_req(0, ALU_ADD, 32'd4, 32'd4);
    #1;
    chk("wrap_r0_ready", {28'b0, bus.req_ready}, 32'h1);
    tick();
    bus.req_valid[0] = 1'b0;
    chk_rsp("wrap_r0", 1'b1, 32'd8, 0, 1'b0);
    #1;
    chk("wrap_r3b_ready", {28'b0, bus.req_ready}, 32'h8);
    tick();
    chk_rsp("wrap_r3b", 1'b1, 32'd6, 3, 1'b0);

    // ---- reset mid-flight ----
    clr();
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    tick();
    clr();
    chk("mid_pending", {31'b0, bus.rsp_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_rsp("mid_reset", 1'b0, 32'd0, 0, 1'b0);
    set_req(2, ALU_ADD, 32'd2, 32'd2);
    set_req(0, ALU_ADD, 32'd7, 32'd0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("mid_ptr_ready", {28'b0, bus.req_ready}, 32'h1);
    tick();
    chk_rsp("mid_r0", 1'b1, 32'd7, 0, 1'b0);

`ifdef ALU_ARB_OPCHECK_EN
    // ---- illegal code flagged, then cleared by a legal op ----
    clr();
    reset_pulse();
    bus.rsp_ready = 1'b1;
    set_req(1, 6'd0, 32'd1, 32'd1);
    #1;
    chk("opc_ready", {28'b0, bus.req_ready}, 32'h2);
    tick();
    bus.req_valid = '0;
    chk_rsp("opc_bad", 1'b1, 32'd0, 1, 1'b1);
    set_req(2, ALU_ADD, 32'd1, 32'd1);
    tick();
    bus.req_valid = '0;
    chk_rsp("opc_good", 1'b1, 32'd2, 2, 1'b0);
`endif

    // ---- randomized traffic against the reference model ----
    clr();
    reset_pulse();
    for (int i = 0; i < NR; i++) m_act[i] = 1'b0;
    m_vld = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!m_act[i] && ($urandom_range(0, 1) == 1)) begin
          int sel;
          m_act[i] = 1'b1;
          sel = $urandom_range(0, 7);
          case (sel)
            0: p_f[i] = ALU_ADD;
            1: p_f[i] = ALU_SUB;
            2: p_f[i] = ALU_AND;
            3: p_f[i] = ALU_OR;
            4, 5: p_f[i] = ALU_SLT;
            6: p_f[i] = ALU_ADD;
            default: p_f[i] = 6'($urandom_range(0, 63));
          endcase
          p_a[i] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
          p_b[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        bus.req_valid[i]          = m_act[i];
        bus.req_signal[i*6 +: 6]  = p_f[i];
        bus.req_dataA[i*32 +: 32] = p_a[i];
        bus.req_dataB[i*32 +: 32] = p_b[i];
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 39) == 0);

      g = -1;
      if (!reset && (!m_vld || bus.rsp_ready)) begin
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && m_act[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        end
      end
      exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
      #1;
      chk($sformatf("rnd%0d_ready", c), {28'b0, bus.req_ready}, {28'b0, exp_rdy});
      tick();

      if (reset) begin
        m_vld = 1'b0; m_data = '0; m_id = 0; m_err = 1'b0; m_ptr = 0;
      end else if (g >= 0) begin
        m_vld  = 1'b1;
        m_err  = OPCHK && ref_illegal(p_f[g]);
        m_data = m_err ? 32'd0 : ref_alu(p_f[g], p_a[g], p_b[g]);
        m_id   = g;
        m_ptr  = (g + 1) % NR;
        m_act[g] = 1'b0;
      end else if (bus.rsp_ready) begin
        m_vld = 1'b0;
      end
      reset = 1'b0;
      chk_rsp($sformatf("rnd%0d", c), m_vld, m_data, m_id, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
